// File: rtl/mio_uart_tx_pkg.sv
// Shared definitions for the MIO UART transmitter: FSM state encodings,
// status-word bit positions and the device's MIO address.
package mio_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int STAT_OVF   = 15;
  localparam int STAT_BUSY  = 14;
  localparam int STAT_FULL  = 13;
  localparam int STAT_EMPTY = 12;
  localparam int STAT_CNT_W = 5;

  localparam logic [31:0] UART_TX_ADDR = 32'hE000_0400;

endpackage

// File: rtl/mio_uart_tx_fifo.sv
// Byte FIFO for the UART transmitter: synchronous push/pop, async clear,
// show-ahead read data, full/empty/count flags. Pointers wrap modulo depth.
module mio_uart_tx_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is not reset; count/pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);

endmodule

// File: rtl/mio_uart_tx.sv
// MIO UART transmitter: FIFO-buffered 8N1 serialiser, LSB first, with status word.
// Define UART_PARITY_EN to insert an even-parity bit between data and stop.
//
// state  | meaning
// IDLE   | line idle (txd=1); pops the next byte as soon as the FIFO has one
// START  | start bit (txd=0) for DIV clocks
// DATA   | eight data bits, LSB first, DIV clocks each
// PARITY | even parity of the byte (only with UART_PARITY_EN)
// STOP   | stop bit (txd=1); at its last tick chains the next byte or returns to IDLE
module mio_uart_tx
  import mio_uart_tx_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int BAUD    = 115200,
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic        we,
  input  logic [7:0]  wdata,
  input  logic        ovf_clr,
  output logic        txd,
  output logic        tx_busy,
  output logic        irq_empty,
  output logic [31:0] status
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] TICK_CNT = CW'(DIV - 1);

  uart_state_e      state;
  logic [CW-1:0]    baud_cnt;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;
  logic             ovf;
  logic             tick;
  logic             pop;
  logic             push;
  logic [7:0]       fifo_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_count;
`ifdef UART_PARITY_EN
  logic             par_bit;
`endif

  assign tick = (state != ST_IDLE) && (baud_cnt == TICK_CNT);
  assign pop  = !fifo_empty && ((state == ST_IDLE) || ((state == ST_STOP) && tick));
  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign push = we && (!fifo_full || pop);

  mio_uart_tx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk       (clk),
    .rst_n     (RSTN),
    .push      (push),
    .push_data (wdata),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      shift     <= '0;
      bit_idx   <= '0;
      txd       <= 1'b1;
      irq_empty <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      irq_empty <= 1'b0;
      if ((state == ST_IDLE) || tick) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (pop) begin
            shift <= fifo_data;
`ifdef UART_PARITY_EN
            par_bit <= ^fifo_data;
`endif
            txd   <= 1'b0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            txd     <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              txd   <= par_bit;
              state <= ST_PARITY;
`else
              txd   <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              txd     <= shift[0];
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            txd   <= 1'b1;
            state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (pop) begin
              // Back-to-back frame: next start bit follows the stop bit directly.
              shift <= fifo_data;
`ifdef UART_PARITY_EN
              par_bit <= ^fifo_data;
`endif
              txd   <= 1'b0;
              state <= ST_START;
            end else begin
              txd       <= 1'b1;
              state     <= ST_IDLE;
              irq_empty <= 1'b1;
            end
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Overflow is sticky; a coincident clear loses to a new overflow.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN)                            ovf <= 1'b0;
    else if (we && fifo_full && !pop)     ovf <= 1'b1;
    else if (ovf_clr)                     ovf <= 1'b0;
  end

  assign tx_busy = (state != ST_IDLE) || !fifo_empty;

  always_comb begin
    status                   = '0;
    status[STAT_OVF]         = ovf;
    status[STAT_BUSY]        = tx_busy;
    status[STAT_FULL]        = fifo_full;
    status[STAT_EMPTY]       = fifo_empty;
    status[STAT_CNT_W-1:0]   = STAT_CNT_W'(fifo_count);
  end

endmodule
